// File: rtl/vx_vpu_states_table_pkg.sv
// Shared types and constants for the VPU-states table.
//  vpu_vtype_t      : {vill, vma, vta, vsew[2:0], vlmul[2:0]}
//  vpu_states_t     : {vl, vtype}, the per-warp architectural vector configuration
//  VPU_STATES_RESET : vl=0, vill=1, every other vtype field 0
//  nw_width()       : warp-id width, never narrower than one bit
//  cnt_width()      : width of a counter that must reach max_pending
package vx_vpu_states_table_pkg;

  localparam int VLEN    = 256;
  // vl can reach VLMAX = VLEN (LMUL=8, SEW=8), so one more bit than log2(VLEN).
  localparam int VL_BITS = $clog2(VLEN) + 1;

  typedef struct packed {
    logic       vill;
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vpu_vtype_t;

  typedef struct packed {
    logic [VL_BITS-1:0] vl;
    vpu_vtype_t         vtype;
  } vpu_states_t;

  localparam int VPU_STATES_W = $bits(vpu_states_t);

  localparam vpu_states_t VPU_STATES_RESET = '{
    vl:    '0,
    vtype: '{vill: 1'b1, vma: 1'b0, vta: 1'b0, vsew: 3'd0, vlmul: 3'd0}
  };

  function automatic int nw_width(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  function automatic int cnt_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/vx_vpu_states_table_if.sv
// VPU-states write-back interface: the VPU (master) pushes a new {vl, vtype}
// for one warp; the states table (slave) always accepts, so there is no ready.
//  st_valid : update valid this cycle
//  st_wid   : warp being updated
//  st_data  : new vpu_states_t
interface vx_vpu_states_table_if
  import vx_vpu_states_table_pkg::*;
#(
  parameter int NUM_WARPS = 8
) ();

  localparam int NW_WIDTH = nw_width(NUM_WARPS);

  logic                st_valid;
  logic [NW_WIDTH-1:0] st_wid;
  vpu_states_t         st_data;

  modport master (output st_valid, output st_wid, output st_data);
  modport slave  (input  st_valid, input  st_wid, input  st_data);

endinterface

// File: rtl/vx_vpu_pend_counter.sv
// Saturating up/down counter of in-flight vsetvl* ops for one warp.
//  inc        : a vsetvl* was issued
//  dec        : its state update came back
//  count      : registered count
//  count_next : value count takes at the coming edge
//  ovf / udf  : one-cycle flags for an increment at MAX_PENDING or a decrement at zero
// Increment and decrement in the same cycle cancel, and neither error flag fires
// in that case, even at the limits.
module vx_vpu_pend_counter
  import vx_vpu_states_table_pkg::*;
#(
  parameter  int MAX_PENDING = 3,
  localparam int CW          = cnt_width(MAX_PENDING)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          ovf,
  output logic          udf
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    count_next = count;
    ovf        = 1'b0;
    udf        = 1'b0;
    unique case ({inc, dec})
      2'b10: begin
        if (count == MAX_CNT) ovf = 1'b1;
        else                  count_next = count + 1'b1;
      end
      2'b01: begin
        if (count == '0) udf = 1'b1;
        else             count_next = count - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) count <= '0;
    else          count <= count_next;
  end

endmodule

// File: rtl/vx_vpu_states_table.sv
// Per-warp vector configuration table beside the issue stage.
//  clk, reset_n     : clock, asynchronous active-low reset
//  st_if (slave)    : {vl, vtype} write-back from the VPU, always accepted
//  cfg_issue_valid/
//  cfg_issue_wid    : a vsetvl* was issued for this warp (pending count up)
//  rd_req_valid/
//  rd_req_wid       : read a warp's state; answered exactly one cycle later
//  rd_rsp_valid     : response valid
//  rd_rsp_data      : state after the request cycle's write (write-first bypass),
//                     holds its last value while idle
//  rd_rsp_pending   : warp's pending count was nonzero after the request cycle
//  pending_mask     : bit w set while warp w has a vsetvl* in flight
//  err_overflow     : sticky, an issue arrived at MAX_PENDING
//  err_underflow    : sticky, an update arrived with nothing pending
// Warp ids at or beyond NUM_WARPS never match an entry: updates and issues to
// them are dropped and reads return VPU_STATES_RESET with pending clear.
module vx_vpu_states_table
  import vx_vpu_states_table_pkg::*;
#(
  parameter  int NUM_WARPS   = 8,
  parameter  int MAX_PENDING = 3,
  localparam int NW_WIDTH    = nw_width(NUM_WARPS),
  localparam int CW          = cnt_width(MAX_PENDING)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vx_vpu_states_table_if.slave st_if,
  input  logic                 cfg_issue_valid,
  input  logic [NW_WIDTH-1:0]  cfg_issue_wid,
  input  logic                 rd_req_valid,
  input  logic [NW_WIDTH-1:0]  rd_req_wid,
  output logic                 rd_rsp_valid,
  output vpu_states_t          rd_rsp_data,
  output logic                 rd_rsp_pending,
  output logic [NUM_WARPS-1:0] pending_mask,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  vpu_states_t          states     [NUM_WARPS];
  logic [CW-1:0]        count      [NUM_WARPS];
  logic [CW-1:0]        count_next [NUM_WARPS];
  logic [NUM_WARPS-1:0] st_sel;
  logic [NUM_WARPS-1:0] is_sel;
  logic [NUM_WARPS-1:0] ovf;
  logic [NUM_WARPS-1:0] udf;

  // One-hot decode per warp; an out-of-range id simply selects nothing.
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign st_sel[w] = st_if.st_valid   && (st_if.st_wid  == NW_WIDTH'(w));
    assign is_sel[w] = cfg_issue_valid  && (cfg_issue_wid == NW_WIDTH'(w));

    vx_vpu_pend_counter #(
      .MAX_PENDING (MAX_PENDING)
    ) u_pend (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc        (is_sel[w]),
      .dec        (st_sel[w]),
      .count      (count[w]),
      .count_next (count_next[w]),
      .ovf        (ovf[w]),
      .udf        (udf[w])
    );

    assign pending_mask[w] = (count[w] != '0);
  end

  // NOTE: the state array is plain flops and is reset, because reads right after reset must see vill=1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) states[w] <= VPU_STATES_RESET;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (st_sel[w]) states[w] <= st_if.st_data;
      end
    end
  end

  // Read mux with write-first bypass; pending comes from the post-edge count.
  vpu_states_t rd_data_d;
  logic        rd_pend_d;

  always_comb begin
    rd_data_d = VPU_STATES_RESET;
    rd_pend_d = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (rd_req_wid == NW_WIDTH'(w)) begin
        rd_data_d = st_sel[w] ? st_if.st_data : states[w];
        rd_pend_d = (count_next[w] != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_rsp_valid   <= 1'b0;
      rd_rsp_data    <= '0;
      rd_rsp_pending <= 1'b0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      rd_rsp_valid <= rd_req_valid;
      if (rd_req_valid) begin
        rd_rsp_data    <= rd_data_d;
        rd_rsp_pending <= rd_pend_d;
      end
      err_overflow  <= err_overflow  | (|ovf);
      err_underflow <= err_underflow | (|udf);
    end
  end

endmodule

// File: tb/tb_vx_vpu_states_table.sv
module tb_vx_vpu_states_table;
  import vx_vpu_states_table_pkg::*;

  // Six warps on a 3-bit id leaves ids 6 and 7 to exercise the out-of-range rules.
  localparam int NW   = 6;
  localparam int MAXP = 3;
  localparam int NWW  = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vx_vpu_states_table_if #(.NUM_WARPS(NW)) st_if ();

  logic           cfg_issue_valid;
  logic [NWW-1:0] cfg_issue_wid;
  logic           rd_req_valid;
  logic [NWW-1:0] rd_req_wid;
  logic           rd_rsp_valid;
  vpu_states_t    rd_rsp_data;
  logic           rd_rsp_pending;
  logic [NW-1:0]  pending_mask;
  logic           err_overflow;
  logic           err_underflow;

  vx_vpu_states_table #(
    .NUM_WARPS   (NW),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .st_if           (st_if),
    .cfg_issue_valid (cfg_issue_valid),
    .cfg_issue_wid   (cfg_issue_wid),
    .rd_req_valid    (rd_req_valid),
    .rd_req_wid      (rd_req_wid),
    .rd_rsp_valid    (rd_rsp_valid),
    .rd_rsp_data     (rd_rsp_data),
    .rd_rsp_pending  (rd_rsp_pending),
    .pending_mask    (pending_mask),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural state, in-flight counts, sticky errors, expected response.
  vpu_states_t m_state [NW];
  int          m_cnt   [NW];
  bit          m_ovf, m_udf;
  bit          e_valid, e_pend;
  vpu_states_t e_data;

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      m_state[w] = VPU_STATES_RESET;
      m_cnt[w]   = 0;
    end
    m_ovf = 0; m_udf = 0;
    e_valid = 0; e_pend = 0; e_data = '0;
  endtask

  function automatic logic [NW-1:0] model_mask();
    logic [NW-1:0] m;
    for (int w = 0; w < NW; w++) m[w] = (m_cnt[w] != 0);
    return m;
  endfunction

  function automatic vpu_states_t mk(input int vl, input int vsew);
    vpu_states_t s;
    s = '0;
    s.vl         = VL_BITS'(vl);
    s.vtype.vsew = 3'(vsew);
    return s;
  endfunction

  task automatic drive_idle();
    st_if.st_valid = 0; st_if.st_wid = '0; st_if.st_data = '0;
    cfg_issue_valid = 0; cfg_issue_wid = '0;
    rd_req_valid = 0; rd_req_wid = '0;
  endtask

  // Drive one cycle, advance the model by the same cycle, sample #1 after the edge.
  task automatic step(input bit sv, input logic [NWW-1:0] sw, input vpu_states_t sd,
                      input bit iv, input logic [NWW-1:0] iw,
                      input bit rv, input logic [NWW-1:0] rw);
    bit st_ok, is_ok;
    st_if.st_valid = sv; st_if.st_wid = sw; st_if.st_data = sd;
    cfg_issue_valid = iv; cfg_issue_wid = iw;
    rd_req_valid = rv; rd_req_wid = rw;

    st_ok = sv && (int'(sw) < NW);
    is_ok = iv && (int'(iw) < NW);
    if (st_ok) m_state[sw] = sd;
    if (!(st_ok && is_ok && sw == iw)) begin
      if (is_ok) begin
        if (m_cnt[iw] == MAXP) m_ovf = 1; else m_cnt[iw]++;
      end
      if (st_ok) begin
        if (m_cnt[sw] == 0) m_udf = 1; else m_cnt[sw]--;
      end
    end
    e_valid = rv;
    if (rv) begin
      if (int'(rw) < NW) begin
        e_data = m_state[rw]; e_pend = (m_cnt[rw] != 0);
      end else begin
        e_data = VPU_STATES_RESET; e_pend = 0;
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, 0, '0);
  endtask

  task automatic test_reset();
    // Outputs while reset is held from power-up.
    n_checks++;
    if ({rd_rsp_valid, rd_rsp_data, rd_rsp_pending, pending_mask, err_overflow, err_underflow} !== '0)
      $display("FAIL reset_initial got valid=%0b data=%h pend=%0b mask=%h ovf=%0b udf=%0b want all 0",
               rd_rsp_valid, rd_rsp_data, rd_rsp_pending, pending_mask, err_overflow, err_underflow);
    else n_pass++;

    @(negedge clk); reset_n = 1; model_reset(); drive_idle();
    @(posedge clk); #1;

    // Traffic, then a read is in flight when reset hits asynchronously.
    step(0, '0, '0, 1, 3'd0, 0, '0);
    step(1, 3'd2, mk(9, 1), 1, 3'd1, 0, '0);
    step(0, '0, '0, 1, 3'd4, 1, 3'd2);
    n_checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== e_data)
      $display("FAIL reset_pre_traffic got valid=%0b data=%h want valid=1 data=%h", rd_rsp_valid, rd_rsp_data, e_data);
    else n_pass++;

    rd_req_valid = 1; rd_req_wid = 3'd4;
    #2 reset_n = 0;
    #1;
    n_checks++;
    if ({rd_rsp_valid, rd_rsp_data, rd_rsp_pending, pending_mask, err_overflow, err_underflow} !== '0)
      $display("FAIL reset_async got valid=%0b data=%h pend=%0b mask=%h ovf=%0b udf=%0b want all 0",
               rd_rsp_valid, rd_rsp_data, rd_rsp_pending, pending_mask, err_overflow, err_underflow);
    else n_pass++;

    @(posedge clk); #1;
    n_checks++;
    if (rd_rsp_valid !== 1'b0)
      $display("FAIL reset_drop_rsp got valid=%0b want 0", rd_rsp_valid);
    else n_pass++;

    #2 reset_n = 1; model_reset(); drive_idle();
    step(0, '0, '0, 0, '0, 1, 3'd3);
    n_checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_data.vl !== '0 || rd_rsp_data.vtype.vill !== 1'b1 ||
        rd_rsp_data !== VPU_STATES_RESET || rd_rsp_pending !== 1'b0)
      $display("FAIL reset_read_w3 got valid=%0b data=%h pend=%0b want valid=1 data=%h pend=0",
               rd_rsp_valid, rd_rsp_data, rd_rsp_pending, VPU_STATES_RESET);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    step(0, '0, '0, 1, 3'd0, 0, '0);
    step(1, 3'd0, mk(3, 0), 1, 3'd0, 1, 3'd0);
    n_checks++;
    if (pending_mask[0] !== 1'b1 || err_overflow !== 1'b0 || err_underflow !== 1'b0 ||
        rd_rsp_data !== mk(3, 0) || rd_rsp_pending !== 1'b1)
      $display("FAIL simul_cnt1 got mask=%h ovf=%0b udf=%0b data=%h pend=%0b want mask0=1 ovf=0 udf=0 data=%h pend=1",
               pending_mask, err_overflow, err_underflow, rd_rsp_data, rd_rsp_pending, mk(3, 0));
    else n_pass++;

    // Back to zero, then issue+update together at zero and at the maximum.
    step(1, 3'd0, mk(4, 0), 0, '0, 0, '0);
    step(1, 3'd0, mk(5, 0), 1, 3'd0, 0, '0);
    n_checks++;
    if (pending_mask !== '0 || err_underflow !== 1'b0)
      $display("FAIL simul_at_zero got mask=%h udf=%0b want mask=0 udf=0", pending_mask, err_underflow);
    else n_pass++;

    repeat (MAXP) step(0, '0, '0, 1, 3'd0, 0, '0);
    step(1, 3'd0, mk(6, 0), 1, 3'd0, 0, '0);
    n_checks++;
    if (pending_mask !== model_mask() || err_overflow !== 1'b0)
      $display("FAIL simul_at_max got mask=%h ovf=%0b want mask=%h ovf=0", pending_mask, err_overflow, model_mask());
    else n_pass++;

    repeat (MAXP) step(1, 3'd0, mk(8, 0), 0, '0, 0, '0);
    n_checks++;
    if (pending_mask !== '0 || err_underflow !== 1'b0 || err_overflow !== 1'b0)
      $display("FAIL simul_drain got mask=%h ovf=%0b udf=%0b want 0 0 0", pending_mask, err_overflow, err_underflow);
    else n_pass++;
  endtask

  task automatic test_pending();
    repeat (3) step(0, '0, '0, 1, 3'd1, 0, '0);
    n_checks++;
    if (pending_mask !== 6'h02 || err_overflow !== 1'b0)
      $display("FAIL pend_three got mask=%h ovf=%0b want mask=02 ovf=0", pending_mask, err_overflow);
    else n_pass++;

    step(0, '0, '0, 1, 3'd1, 0, '0);
    n_checks++;
    if (err_overflow !== 1'b1 || pending_mask !== 6'h02)
      $display("FAIL pend_overflow got ovf=%0b mask=%h want ovf=1 mask=02", err_overflow, pending_mask);
    else n_pass++;

    // Exactly three updates must drain it, proving the count saturated at 3.
    step(1, 3'd1, mk(1, 1), 0, '0, 0, '0);
    step(1, 3'd1, mk(2, 1), 0, '0, 0, '0);
    n_checks++;
    if (pending_mask !== 6'h02)
      $display("FAIL pend_two_left got mask=%h want 02", pending_mask);
    else n_pass++;
    step(1, 3'd1, mk(3, 1), 0, '0, 0, '0);
    n_checks++;
    if (pending_mask !== 6'h00 || err_underflow !== 1'b0)
      $display("FAIL pend_drained got mask=%h udf=%0b want mask=00 udf=0", pending_mask, err_underflow);
    else n_pass++;

    step(1, 3'd1, mk(33, 3), 0, '0, 1, 3'd1);
    n_checks++;
    if (err_underflow !== 1'b1 || rd_rsp_data !== mk(33, 3) || rd_rsp_pending !== 1'b0 || err_overflow !== 1'b1)
      $display("FAIL pend_underflow got udf=%0b data=%h pend=%0b ovf=%0b want udf=1 data=%h pend=0 ovf=1",
               err_underflow, rd_rsp_data, rd_rsp_pending, err_overflow, mk(33, 3));
    else n_pass++;
  endtask

  task automatic test_write_read();
    step(1, 3'd2, mk(16, 2), 0, '0, 0, '0);
    n_checks++;
    if (rd_rsp_valid !== 1'b0)
      $display("FAIL wr_no_req got valid=%0b want 0", rd_rsp_valid);
    else n_pass++;
    step(0, '0, '0, 0, '0, 1, 3'd2);
    n_checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_data.vl !== VL_BITS'(16) || rd_rsp_data.vtype.vsew !== 3'd2 ||
        rd_rsp_data.vtype.vill !== 1'b0)
      $display("FAIL wr_read_w2 got valid=%0b data=%h want valid=1 data=%h", rd_rsp_valid, rd_rsp_data, mk(16, 2));
    else n_pass++;
    idle();
    n_checks++;
    if (rd_rsp_valid !== 1'b0 || rd_rsp_data !== mk(16, 2))
      $display("FAIL wr_hold got valid=%0b data=%h want valid=0 data=%h", rd_rsp_valid, rd_rsp_data, mk(16, 2));
    else n_pass++;
  endtask

  task automatic test_bypass();
    step(1, 3'd5, mk(7, 0), 0, '0, 1, 3'd5);
    n_checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_data.vl !== VL_BITS'(7) || rd_rsp_data !== mk(7, 0))
      $display("FAIL bypass_w5 got valid=%0b data=%h want valid=1 data=%h", rd_rsp_valid, rd_rsp_data, mk(7, 0));
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [NW-1:0] mask_before;
    mask_before = pending_mask;
    step(1, 3'd6, mk(99, 3), 1, 3'd7, 1, 3'd6);
    n_checks++;
    if (pending_mask !== mask_before || rd_rsp_data !== VPU_STATES_RESET || rd_rsp_pending !== 1'b0)
      $display("FAIL oor_ignore got mask=%h data=%h pend=%0b want mask=%h data=%h pend=0",
               pending_mask, rd_rsp_data, rd_rsp_pending, mask_before, VPU_STATES_RESET);
    else n_pass++;
    step(0, '0, '0, 0, '0, 1, 3'd0);
    n_checks++;
    if (rd_rsp_data !== m_state[0])
      $display("FAIL oor_alias got data=%h want %h", rd_rsp_data, m_state[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      step($urandom_range(0, 2) == 0, NWW'($urandom_range(0, 7)), vpu_states_t'(VPU_STATES_W'($urandom)),
           $urandom_range(0, 2) == 0, NWW'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 0, NWW'($urandom_range(0, 7)));
      n_checks++;
      if (rd_rsp_valid !== e_valid || rd_rsp_data !== e_data || (e_valid && rd_rsp_pending !== e_pend))
        $display("FAIL rand_rsp cyc=%0d got valid=%0b data=%h pend=%0b want valid=%0b data=%h pend=%0b",
                 c, rd_rsp_valid, rd_rsp_data, rd_rsp_pending, e_valid, e_data, e_pend);
      else n_pass++;
      n_checks++;
      if (pending_mask !== model_mask() || err_overflow !== m_ovf || err_underflow !== m_udf)
        $display("FAIL rand_flags cyc=%0d got mask=%h ovf=%0b udf=%0b want mask=%h ovf=%0b udf=%0b",
                 c, pending_mask, err_overflow, err_underflow, model_mask(), m_ovf, m_udf);
      else n_pass++;
    end
  endtask

  initial begin
    reset_n = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_simultaneous();
    test_pending();
    test_write_read();
    test_bypass();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
